mem_access: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline. It sits between the EXE/MEM and MEM/WB pipeline registers. It consumes the EXE/MEM register outputs and drives a variable-latency data-memory request/acknowledge bus. It formats load data and store byte-lanes, detects misaligned addresses, and stalls the pipeline while a memory transaction is outstanding.

---
 rtl/mem_access.sv | 154 +++++++++++++++
 tb/tb_mem_access.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MIPS memory-access stage: drives the variable-latency data-memory bus, formats
// load/store data, flags misaligned addresses and stalls the pipeline while busy.
//    state | meaning
//    IDLE  | no access in flight; pass-through, misalignment check, request issue
//    WAIT  | request outstanding, waiting for dm_ack
//    DONE  | read word captured; formatted result presented until MEM/WB accepts
package mips_abb_pkg;
   typedef logic [4:0]  reg_addr;
   typedef logic [31:0] reg_word;
   typedef logic [31:0] dram_addr;
   typedef logic [31:0] dram_data;
   typedef logic [31:0] instr_addr;
   typedef enum logic [3:0] {
      MEMOP_NONE = 4'd0,
      MEMOP_LB   = 4'd1,
      MEMOP_LBU  = 4'd2,
      MEMOP_LH   = 4'd3,
      MEMOP_LHU  = 4'd4,
      MEMOP_LW   = 4'd5,
      MEMOP_SB   = 4'd6,
      MEMOP_SH   = 4'd7,
      MEMOP_SW   = 4'd8
   } memop;
endpackage

module mem_access
   import mips_abb_pkg::*;
(
   input  logic        cpu_clk,
   input  logic        cpu_rst_n,
   input  logic        mem_i_rfwe,
   input  reg_addr     mem_i_rfwa,
   input  reg_word     mem_i_res,
   input  instr_addr   mem_i_pc,
   input  memop        mem_i_memop,
   input  dram_addr    mem_i_addr,
   input  dram_data    mem_i_data,
   input  logic        wb_stall,
   output logic        dm_req,
   output logic        dm_we,
   output dram_addr    dm_addr,
   output logic [3:0]  dm_wstrb,
   output dram_data    dm_wdata,
   input  logic        dm_ack,
   input  dram_data    dm_rdata,
   output logic        mem_o_rfwe,
   output reg_addr     mem_o_rfwa,
   output reg_word     mem_o_res,
   output instr_addr   mem_o_pc,
   output logic [1:0]  mem_o_excp,
   output dram_addr    mem_o_badvaddr,
   output logic        stallreq_mem
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   dram_data    rdata_q;
   logic        is_load;
   logic        is_store;
   logic        misaligned;
   logic        access;
   logic        capture;
   logic [3:0]  wstrb_st;
   dram_data    wdata_st;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   reg_word     load_res;

   always_comb begin
      is_load  = mem_i_memop inside {MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU, MEMOP_LW};
      is_store = mem_i_memop inside {MEMOP_SB, MEMOP_SH, MEMOP_SW};
      misaligned = ((mem_i_memop inside {MEMOP_LH, MEMOP_LHU, MEMOP_SH}) && mem_i_addr[0])
                || ((mem_i_memop inside {MEMOP_LW, MEMOP_SW}) && (mem_i_addr[1:0] != 2'b00));
      access = (is_load || is_store) && !misaligned;
   end

   // The request is masked during reset so an abandoned access drops off the bus at once.
   always_comb begin
      dm_req       = cpu_rst_n && (((state == ST_IDLE) && access) || (state == ST_WAIT));
      capture      = dm_req && dm_ack;
      stallreq_mem = dm_req || ((state == ST_DONE) && wb_stall);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (access) state_nxt = dm_ack ? ST_DONE : ST_WAIT;
         ST_WAIT: if (dm_ack) state_nxt = ST_DONE;
         ST_DONE: if (!wb_stall) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state   <= ST_IDLE;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (capture) rdata_q <= dm_rdata;
      end
   end

   always_comb begin
      wstrb_st = 4'b0000;
      wdata_st = '0;
      case (mem_i_memop)
         MEMOP_SB: begin
            wstrb_st = 4'b0001 << mem_i_addr[1:0];
            wdata_st = {4{mem_i_data[7:0]}};
         end
         MEMOP_SH: begin
            wstrb_st = mem_i_addr[1] ? 4'b1100 : 4'b0011;
            wdata_st = {2{mem_i_data[15:0]}};
         end
         MEMOP_SW: begin
            wstrb_st = 4'b1111;
            wdata_st = mem_i_data;
         end
         default: ;
      endcase
      dm_we    = dm_req && is_store;
      dm_wstrb = dm_we ? wstrb_st : 4'b0000;
      dm_wdata = dm_we ? wdata_st : '0;
      dm_addr  = {mem_i_addr[31:2], 2'b00};
   end

   always_comb begin
      byte_sel = rdata_q[{mem_i_addr[1:0], 3'b000} +: 8];
      half_sel = rdata_q[{mem_i_addr[1], 4'b0000} +: 16];
      case (mem_i_memop)
         MEMOP_LB:  load_res = {{24{byte_sel[7]}}, byte_sel};
         MEMOP_LBU: load_res = {24'h0, byte_sel};
         MEMOP_LH:  load_res = {{16{half_sel[15]}}, half_sel};
         MEMOP_LHU: load_res = {16'h0, half_sel};
         MEMOP_LW:  load_res = rdata_q;
         default:   load_res = '0;
      endcase
   end

   always_comb begin
      mem_o_rfwa     = mem_i_rfwa;
      mem_o_pc       = mem_i_pc;
      mem_o_rfwe     = mem_i_rfwe && !is_store && !misaligned;
      mem_o_res      = ((state == ST_DONE) && is_load) ? load_res : mem_i_res;
      mem_o_excp     = misaligned ? (is_store ? 2'b10 : 2'b01) : 2'b00;
      mem_o_badvaddr = misaligned ? mem_i_addr : '0;
   end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized transactions
// compared against a transaction-level reference model.
module tb_mem_access;
   import mips_abb_pkg::*;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst_n;
   logic        mem_i_rfwe;
   reg_addr     mem_i_rfwa;
   reg_word     mem_i_res;
   instr_addr   mem_i_pc;
   memop        mem_i_memop;
   dram_addr    mem_i_addr;
   dram_data    mem_i_data;
   logic        wb_stall;
   logic        dm_req;
   logic        dm_we;
   dram_addr    dm_addr;
   logic [3:0]  dm_wstrb;
   dram_data    dm_wdata;
   logic        dm_ack;
   dram_data    dm_rdata;
   logic        mem_o_rfwe;
   reg_addr     mem_o_rfwa;
   reg_word     mem_o_res;
   instr_addr   mem_o_pc;
   logic [1:0]  mem_o_excp;
   dram_addr    mem_o_badvaddr;
   logic        stallreq_mem;

   int n_cmp = 0;
   int n_err = 0;

   mem_access dut (
      .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
      .mem_i_rfwe(mem_i_rfwe), .mem_i_rfwa(mem_i_rfwa), .mem_i_res(mem_i_res),
      .mem_i_pc(mem_i_pc), .mem_i_memop(mem_i_memop), .mem_i_addr(mem_i_addr),
      .mem_i_data(mem_i_data), .wb_stall(wb_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_o_rfwe(mem_o_rfwe), .mem_o_rfwa(mem_o_rfwa), .mem_o_res(mem_o_res),
      .mem_o_pc(mem_o_pc), .mem_o_excp(mem_o_excp), .mem_o_badvaddr(mem_o_badvaddr),
      .stallreq_mem(stallreq_mem)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_load(input memop op, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * a[1:0])) & 32'hFF;
      h = (w >> (16 * a[1])) & 32'hFFFF;
      case (op)
         MEMOP_LB:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
         MEMOP_LBU: return b;
         MEMOP_LH:  return h[15] ? (h | 32'hFFFF_0000) : h;
         MEMOP_LHU: return h;
         default:   return w;
      endcase
   endfunction

   function automatic logic [3:0] exp_strb(input memop op, input logic [31:0] a);
      case (op)
         MEMOP_SB: return 4'(1 << a[1:0]);
         MEMOP_SH: return 4'(3 << a[1:0]);
         MEMOP_SW: return 4'hF;
         default:  return 4'h0;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input memop op, input logic [31:0] d);
      case (op)
         MEMOP_SB: return (d & 32'hFF) * 32'h0101_0101;
         MEMOP_SH: return (d & 32'hFFFF) * 32'h0001_0001;
         MEMOP_SW: return d;
         default:  return 32'h0;
      endcase
   endfunction

   // One complete transaction: issue cycle, nwait wait cycles, then DONE held nstall extra cycles.
   task automatic run_txn(input memop op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rword, input logic [31:0] res, input logic rfwe,
                          input int nwait, input int nstall);
      bit ld, st, mis;
      reg_addr rfwa;
      logic [31:0] pc;
      ld  = op inside {MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU, MEMOP_LW};
      st  = op inside {MEMOP_SB, MEMOP_SH, MEMOP_SW};
      mis = ((op == MEMOP_LH || op == MEMOP_LHU || op == MEMOP_SH) && addr[0] == 1'b1)
         || ((op == MEMOP_LW || op == MEMOP_SW) && addr[1:0] != 2'b00);
      rfwa = 5'($urandom);
      pc   = $urandom;
      @(posedge cpu_clk); #1;
      mem_i_memop = op; mem_i_addr = addr; mem_i_data = data;
      mem_i_res = res; mem_i_rfwe = rfwe; mem_i_rfwa = rfwa; mem_i_pc = pc;
      dm_ack   = (nwait == 0) ? 1'b1 : 1'b0;
      dm_rdata = (nwait == 0) ? rword : $urandom;
      wb_stall = 1'($urandom_range(0, 1));
      #3;
      chk("excp", 32'(mem_o_excp), mis ? (st ? 32'd2 : 32'd1) : 32'd0);
      chk("badvaddr", mem_o_badvaddr, mis ? addr : 32'h0);
      chk("pc", mem_o_pc, pc);
      chk("rfwa", 32'(mem_o_rfwa), 32'(rfwa));
      if (!ld && !st) begin
         chk("none_res", mem_o_res, res);
         chk("none_rfwe", 32'(mem_o_rfwe), 32'(rfwe));
         chk("none_req", 32'(dm_req), 0);
         chk("none_stall", 32'(stallreq_mem), 0);
         return;
      end
      if (mis) begin
         chk("mis_req", 32'(dm_req), 0);
         chk("mis_stall", 32'(stallreq_mem), 0);
         chk("mis_rfwe", 32'(mem_o_rfwe), 0);
         return;
      end
      for (int c = 0; c <= nwait; c++) begin
         if (c > 0) begin
            @(posedge cpu_clk); #1;
            dm_ack   = (c == nwait) ? 1'b1 : 1'b0;
            dm_rdata = (c == nwait) ? rword : $urandom;
            wb_stall = 1'($urandom_range(0, 1));
            #3;
         end
         chk("req", 32'(dm_req), 1);
         chk("stall_req", 32'(stallreq_mem), 1);
         chk("we", 32'(dm_we), 32'(st));
         chk("addr", dm_addr, addr & 32'hFFFF_FFFC);
         chk("wstrb", 32'(dm_wstrb), 32'(exp_strb(op, addr)));
         chk("wdata", dm_wdata, exp_wdata(op, data));
      end
      for (int k = 0; k <= nstall; k++) begin
         @(posedge cpu_clk); #1;
         dm_ack   = 1'($urandom_range(0, 1));
         dm_rdata = $urandom;
         wb_stall = (k < nstall) ? 1'b1 : 1'b0;
         #3;
         chk("done_req", 32'(dm_req), 0);
         chk("done_stall", 32'(stallreq_mem), 32'(wb_stall));
         chk("done_rfwe", 32'(mem_o_rfwe), st ? 32'd0 : 32'(rfwe));
         if (ld) chk("load_res", mem_o_res, exp_load(op, addr, rword));
      end
      @(posedge cpu_clk); #1;
      mem_i_memop = MEMOP_NONE; dm_ack = 1'b0; wb_stall = 1'b1;
      #3;
      chk("back_idle", 32'(stallreq_mem), 0);
      wb_stall = 1'b0;
   endtask

   initial begin
      memop op;
      cpu_rst_n = 1'b0;
      mem_i_rfwe = 1'b0; mem_i_rfwa = '0; mem_i_res = '0; mem_i_pc = '0;
      mem_i_memop = MEMOP_LW; mem_i_addr = 32'h40; mem_i_data = '0;
      wb_stall = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
      #12;
      chk("rst_req", 32'(dm_req), 0);
      chk("rst_stall", 32'(stallreq_mem), 0);
      chk("rst_excp", 32'(mem_o_excp), 0);
      mem_i_memop = MEMOP_NONE;
      #10 cpu_rst_n = 1'b1;

      run_txn(MEMOP_NONE, 32'h0, 32'h0, 32'h0, 32'h1234, 1'b1, 0, 0);
      run_txn(MEMOP_SB,  32'h103, 32'hAB, 32'h0, 32'h5555, 1'b1, 3, 0);
      run_txn(MEMOP_LB,  32'h101, 32'h0, 32'h0000_8000, 32'h0, 1'b1, 0, 0);
      run_txn(MEMOP_LBU, 32'h101, 32'h0, 32'h0000_8000, 32'h0, 1'b1, 0, 0);
      run_txn(MEMOP_LH,  32'h102, 32'h0, 32'h8001_0000, 32'h0, 1'b1, 0, 0);
      run_txn(MEMOP_LW,  32'h102, 32'h0, 32'h0, 32'h0, 1'b1, 0, 0);
      run_txn(MEMOP_SH,  32'h101, 32'hBEEF, 32'h0, 32'h0, 1'b1, 0, 0);
      run_txn(MEMOP_LW,  32'h100, 32'h0, 32'hCAFE_F00D, 32'h0, 1'b1, 1, 2);
      run_txn(MEMOP_SH,  32'h202, 32'h1234_BEEF, 32'h0, 32'h0, 1'b1, 2, 1);
      run_txn(MEMOP_SW,  32'h300, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 0, 0);

      // Reset while an access is outstanding in WAIT.
      @(posedge cpu_clk); #1;
      mem_i_memop = MEMOP_LW; mem_i_addr = 32'h200; dm_ack = 1'b0; wb_stall = 1'b0;
      @(posedge cpu_clk); #2;
      chk("wait_req", 32'(dm_req), 1);
      cpu_rst_n = 1'b0;
      #1;
      chk("rst_wait_req", 32'(dm_req), 0);
      chk("rst_wait_stall", 32'(stallreq_mem), 0);
      mem_i_memop = MEMOP_NONE;
      @(posedge cpu_clk); #1;
      cpu_rst_n = 1'b1; dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
      #3;
      chk("late_ack_req", 32'(dm_req), 0);
      chk("late_ack_stall", 32'(stallreq_mem), 0);
      @(posedge cpu_clk); #1;
      dm_ack = 1'b0; wb_stall = 1'b1;
      #3;
      chk("late_ack_idle", 32'(stallreq_mem), 0);
      wb_stall = 1'b0;

      for (int i = 0; i < 150; i++) begin
         op = memop'($urandom_range(0, 8));
         run_txn(op, $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
